// File: rtl/morse_tx.sv
// Morse transmitter: turns one 6-bit symbol code into a timed key waveform
// with International Morse element and gap timing. All outputs are registered.
module morse_tx #(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in_valid,
    input  logic [5:0] symbol,
    output logic       in_ready,
    output logic       key,
    output logic       dot,
    output logic       dash,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] Unit1 = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] Unit3 = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] Unit7 = CNT_W'(7 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMark, StSpace, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       pat_q, pat_d;
    logic             key_q, key_d, dot_q, dot_d, dash_q, dash_d;
    logic             in_ready_q, in_ready_d, busy_q, busy_d;
    logic             done_q, done_d, err_q, err_d;

    logic [7:0] rom;  // {len[2:0], pat[4:0]}, pat[len-1] sent first, 1 = dash
    logic [2:0] rom_len;
    logic [4:0] rom_pat;
    assign rom_len = rom[7:5];
    assign rom_pat = rom[4:0];

    always_comb begin
        rom = 8'd0;
        case (symbol)
            6'd0:  rom = {3'd5, 5'b11111};
            6'd1:  rom = {3'd5, 5'b01111};
            6'd2:  rom = {3'd5, 5'b00111};
            6'd3:  rom = {3'd5, 5'b00011};
            6'd4:  rom = {3'd5, 5'b00001};
            6'd5:  rom = {3'd5, 5'b00000};
            6'd6:  rom = {3'd5, 5'b10000};
            6'd7:  rom = {3'd5, 5'b11000};
            6'd8:  rom = {3'd5, 5'b11100};
            6'd9:  rom = {3'd5, 5'b11110};
            6'd10: rom = {3'd2, 5'b00001};
            6'd11: rom = {3'd4, 5'b01000};
            6'd12: rom = {3'd4, 5'b01010};
            6'd13: rom = {3'd3, 5'b00100};
            6'd14: rom = {3'd1, 5'b00000};
            6'd15: rom = {3'd4, 5'b00010};
            6'd16: rom = {3'd3, 5'b00110};
            6'd17: rom = {3'd4, 5'b00000};
            6'd18: rom = {3'd2, 5'b00000};
            6'd19: rom = {3'd4, 5'b00111};
            6'd20: rom = {3'd3, 5'b00101};
            6'd21: rom = {3'd4, 5'b00100};
            6'd22: rom = {3'd2, 5'b00011};
            6'd23: rom = {3'd2, 5'b00010};
            6'd24: rom = {3'd3, 5'b00111};
            6'd25: rom = {3'd4, 5'b00110};
            6'd26: rom = {3'd4, 5'b01101};
            6'd27: rom = {3'd3, 5'b00010};
            6'd28: rom = {3'd3, 5'b00000};
            6'd29: rom = {3'd1, 5'b00001};
            6'd30: rom = {3'd3, 5'b00001};
            6'd31: rom = {3'd4, 5'b00001};
            6'd32: rom = {3'd3, 5'b00011};
            6'd33: rom = {3'd4, 5'b01001};
            6'd34: rom = {3'd4, 5'b01011};
            6'd35: rom = {3'd4, 5'b01100};
            default: rom = 8'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (symbol <= 6'd35) begin
                        state_d = StMark;
                        pat_d   = rom_pat;
                        idx_d   = 3'(rom_len - 3'd1);
                        cnt_d   = rom_pat[idx_d] ? Unit3 : Unit1;
                    end else if (symbol == 6'd36) begin
                        state_d = StGap;
                        cnt_d   = Unit7;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StMark: begin
                if (cnt_q == '0) begin
                    state_d = (idx_q != 3'd0) ? StSpace : StGap;
                    cnt_d   = (idx_q != 3'd0) ? Unit1 : Unit3;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSpace: begin
                if (cnt_q == '0) begin
                    state_d = StMark;
                    idx_d   = 3'(idx_q - 3'd1);
                    cnt_d   = pat_q[idx_d] ? Unit3 : Unit1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are registered copies of what the next state implies.
        key_d      = (state_d == StMark);
        dash_d     = key_d & pat_d[idx_d];
        dot_d      = key_d & ~pat_d[idx_d];
        in_ready_d = (state_d == StIdle);
        busy_d     = ~in_ready_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            pat_q      <= 5'd0;
            key_q      <= 1'b0;
            dot_q      <= 1'b0;
            dash_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pat_q      <= pat_d;
            key_q      <= key_d;
            dot_q      <= dot_d;
            dash_q     <= dash_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign key      = key_q;
    assign dot      = dot_q;
    assign dash     = dash_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: per-cycle waveform compared against a model built from
// Morse strings, plus table vectors, reset-mid-element and random symbols.
module tb_morse_tx;

    localparam int unsigned U = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] symbol = 6'd0;
    logic       in_ready, key, dot, dash, busy, done, err;

    morse_tx #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_valid (in_valid),
        .symbol   (symbol),
        .in_ready (in_ready),
        .key      (key),
        .dot      (dot),
        .dash     (dash),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    string morse_tab [36];
    logic [6:0] exp_q [$];  // {key, dot, dash, in_ready, busy, done, err}

    localparam logic [6:0] IdleVec = 7'b0001000;

    typedef struct {
        int    sym;
        int    done_cycle;  // 0 = no done expected
        string name;
    } vec_t;

    function automatic logic [6:0] sample();
        return {key, dot, dash, in_ready, busy, done, err};
    endfunction

    task automatic check(input string name, input int cyc, input logic [6:0] got,
                         input logic [6:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got {key,dot,dash,rdy,busy,done,err}=%b expected %b",
                     name, cyc, got, want);
        end
    endtask

    // Expected per-cycle outputs after acceptance, ending with the done cycle.
    task automatic build(input int sym);
        string m;
        byte   c;
        exp_q.delete();
        if (sym < 36) begin
            m = morse_tab[sym];
            for (int i = 0; i < m.len(); i++) begin
                c = m[i];
                for (int k = 0; k < ((c == "-") ? 3 * U : U); k++)
                    exp_q.push_back({1'b1, c == ".", c == "-", 4'b0100});
                if (i < m.len() - 1)
                    for (int k = 0; k < U; k++) exp_q.push_back(7'b0000100);
            end
            for (int k = 0; k < 3 * U; k++) exp_q.push_back(7'b0000100);
            exp_q.push_back(7'b0001010);
        end else if (sym == 36) begin
            for (int k = 0; k < 7 * U; k++) exp_q.push_back(7'b0000100);
            exp_q.push_back(7'b0001010);
        end else begin
            exp_q.push_back(7'b0001001);
        end
    endtask

    task automatic offer(input int sym);
        in_valid = 1'b1;
        symbol   = 6'(sym);
    endtask

    // Called right after offer(); returns at the negedge of the final cycle.
    task automatic check_sym(input int sym, input string name, output int done_at);
        int n;
        build(sym);
        n = exp_q.size();
        done_at = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                in_valid = 1'b0;
                symbol   = 6'($urandom);
            end
            if (k == 3 && n > 4) in_valid = 1'b1;  // must be ignored while busy
            if (k == 4 && n > 4) in_valid = 1'b0;
            if (done && done_at == 0) done_at = k;
            check(name, k, sample(), exp_q[k-1]);
        end
    endtask

    vec_t vecs [6];
    int   d;

    initial begin
        morse_tab = '{"-----", ".----", "..---", "...--", "....-",
                      ".....", "-....", "--...", "---..", "----.",
                      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                      "-.--", "--.."};
        vecs = '{'{14, 9, "E"}, '{10, 17, "A"}, '{0, 45, "zero"},
                 '{36, 15, "wordspace"}, '{29, 13, "T_b2b"}, '{40, 0, "invalid40"}};

        repeat (3) @(negedge Clock);
        check("reset_state", 0, sample(), IdleVec);
        Reset = 1'b0;
        @(negedge Clock);
        check("idle_after_reset", 0, sample(), IdleVec);

        // Vectors run back-to-back: each is offered on the previous done cycle.
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].sym);
            check_sym(vecs[i].sym, vecs[i].name, d);
            tests++;
            if (d != vecs[i].done_cycle) begin
                fails++;
                $display("FAIL %s_done_cycle: got %0d expected %0d",
                         vecs[i].name, d, vecs[i].done_cycle);
            end
        end
        offer(14);
        check_sym(14, "E_after_err", d);

        // Reset in the 3rd cycle of M's first dash.
        offer(22);
        @(negedge Clock);
        in_valid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("M_dash_cycle3", 3, sample(), 7'b1010100);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_mid_dash", 4, sample(), IdleVec);
        Reset = 1'b0;
        @(negedge Clock);
        check("no_residual_done", 5, sample(), IdleVec);
        offer(14);
        check_sym(14, "E_after_reset", d);
        tests++;
        if (d != 9) begin
            fails++;
            $display("FAIL E_after_reset_done_cycle: got %0d expected 9", d);
        end

        for (int i = 0; i < 40; i++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(36, 63))
                                            : int'($urandom_range(0, 35));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge Clock);
                    check("random_idle", 0, sample(), IdleVec);
                end
            end
            offer(s);
            check_sym(s, $sformatf("random_sym%0d", s), d);
        end

        in_valid = 1'b0;
        @(negedge Clock);
        check("final_idle", 0, sample(), IdleVec);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
